// File: rtl/cmd_dispatch.sv
// Device-side command responder: assembles 3-byte host frames, executes them against
// the config registers and the pot/EEPROM/dump ports, and returns one response byte.
module cmd_dispatch #(
  parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       clr_rx_rdy,
  output logic [7:0] tx_data,
  output logic       trmt,
  input  logic       tx_done,
  output logic       pot_wrt,
  output logic [1:0] pot_sel,
  output logic [7:0] pot_val,
  input  logic       pot_done,
  output logic       eep_wrt,
  output logic       eep_rd,
  output logic [5:0] eep_addr,
  output logic [7:0] eep_wdata,
  input  logic [7:0] eep_rdata,
  input  logic       eep_done,
  output logic       dump_start,
  output logic [1:0] dump_ch,
  input  logic [7:0] dump_byte,
  input  logic       dump_vld,
  output logic       dump_sent,
  input  logic       dump_end,
  input  logic       capt_done,
  output logic [2:0] gain1,
  output logic [2:0] gain2,
  output logic [2:0] gain3,
  output logic [7:0] trig_lvl,
  output logic [8:0] trig_pos,
  output logic [3:0] decimator,
  output logic [5:0] trig_cfg
);

  typedef enum logic [3:0] {
    BYTE1, BYTE2, BYTE3, EXEC, POT_WAIT, EEP_WAIT, DMP_WAIT, DMP_TX, RESP
  } state_t;

  localparam logic [7:0] OP_DUMP = 8'h01;
  localparam logic [7:0] OP_GAIN = 8'h02;
  localparam logic [7:0] OP_LVL  = 8'h03;
  localparam logic [7:0] OP_POS  = 8'h04;
  localparam logic [7:0] OP_DEC  = 8'h05;
  localparam logic [7:0] OP_CFG  = 8'h06;
  localparam logic [7:0] OP_RD   = 8'h07;
  localparam logic [7:0] OP_EWR  = 8'h08;
  localparam logic [7:0] OP_ERD  = 8'h09;
  localparam logic [7:0] ACK     = 8'hA5;
  localparam logic [7:0] NACK    = 8'hEE;

  state_t      state, state_nxt;
  logic [7:0]  op, arg3;
  logic [5:0]  arg2;
  logic [19:0] tmr;
  logic        end_pend;
  logic        in_frame, accept, tmr_hit, lvl_ok;
  logic [7:0]  lut_val, tx_nxt;
  logic        trmt_nxt, pot_wrt_nxt, eep_wrt_nxt, eep_rd_nxt;
  logic        dump_start_nxt, dump_sent_nxt;

  assign in_frame = (state == BYTE1) || (state == BYTE2) || (state == BYTE3);
  // The UART drops rx_rdy only after seeing clr_rx_rdy, so skip the cycle it is still stale.
  assign accept   = in_frame && rx_rdy && !clr_rx_rdy;
  assign tmr_hit  = (tmr == TIMEOUT);
  assign lvl_ok   = (arg3 >= 8'd46) && (arg3 <= 8'd201);

  always_comb begin
    unique case (arg2[4:2])
      3'd0: lut_val = 8'h02;
      3'd1: lut_val = 8'h05;
      3'd2: lut_val = 8'h09;
      3'd3: lut_val = 8'h0F;
      3'd4: lut_val = 8'h1C;
      3'd5: lut_val = 8'h2E;
      3'd6: lut_val = 8'h47;
      default: lut_val = 8'h57;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt      = state;
    tx_nxt         = tx_data;
    trmt_nxt       = 1'b0;
    pot_wrt_nxt    = 1'b0;
    eep_wrt_nxt    = 1'b0;
    eep_rd_nxt     = 1'b0;
    dump_start_nxt = 1'b0;
    dump_sent_nxt  = 1'b0;
    unique case (state)
      BYTE1: if (accept) state_nxt = BYTE2;
      BYTE2: if (accept) state_nxt = BYTE3; else if (tmr_hit) state_nxt = BYTE1;
      BYTE3: if (accept) state_nxt = EXEC;  else if (tmr_hit) state_nxt = BYTE1;
      EXEC: begin
        state_nxt = RESP;
        trmt_nxt  = 1'b1;
        tx_nxt    = ACK;
        case (op)
          OP_DUMP: begin
            if (arg2[1:0] == 2'd3) tx_nxt = NACK;
            else begin
              trmt_nxt       = 1'b0;
              dump_start_nxt = 1'b1;
              state_nxt      = DMP_WAIT;
            end
          end
          OP_GAIN: begin
            if (arg2[1:0] == 2'd3) tx_nxt = NACK;
            else begin
              trmt_nxt    = 1'b0;
              pot_wrt_nxt = 1'b1;
              state_nxt   = POT_WAIT;
            end
          end
          OP_LVL: begin
            if (!lvl_ok) tx_nxt = NACK;
            else begin
              trmt_nxt    = 1'b0;
              pot_wrt_nxt = 1'b1;
              state_nxt   = POT_WAIT;
            end
          end
          OP_POS, OP_DEC, OP_CFG: tx_nxt = ACK;
          OP_RD: tx_nxt = {2'b00, trig_cfg};
          OP_EWR: begin
            trmt_nxt    = 1'b0;
            eep_wrt_nxt = 1'b1;
            state_nxt   = EEP_WAIT;
          end
          OP_ERD: begin
            trmt_nxt   = 1'b0;
            eep_rd_nxt = 1'b1;
            state_nxt  = EEP_WAIT;
          end
          default: tx_nxt = NACK;
        endcase
      end
      POT_WAIT: if (pot_done) begin
        trmt_nxt  = 1'b1;
        tx_nxt    = ACK;
        state_nxt = RESP;
      end
      EEP_WAIT: if (eep_done) begin
        trmt_nxt  = 1'b1;
        tx_nxt    = (op == OP_ERD) ? eep_rdata : ACK;
        state_nxt = RESP;
      end
      DMP_WAIT: begin
        // dump_vld may still be high in the cycle dump_sent acknowledges the previous byte.
        if (dump_vld && !dump_sent) begin
          trmt_nxt  = 1'b1;
          tx_nxt    = dump_byte;
          state_nxt = DMP_TX;
        end else if (dump_end) begin
          state_nxt = BYTE1;
        end
      end
      DMP_TX: if (tx_done) begin
        dump_sent_nxt = 1'b1;
        state_nxt     = end_pend ? BYTE1 : DMP_WAIT;
      end
      RESP: if (tx_done) state_nxt = BYTE1;
      default: state_nxt = BYTE1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BYTE1;
      op         <= 8'h00;
      arg2       <= 6'h00;
      arg3       <= 8'h00;
      tmr        <= 20'h0;
      end_pend   <= 1'b0;
      clr_rx_rdy <= 1'b0;
      tx_data    <= 8'h00;
      trmt       <= 1'b0;
      pot_wrt    <= 1'b0;
      eep_wrt    <= 1'b0;
      eep_rd     <= 1'b0;
      dump_start <= 1'b0;
      dump_sent  <= 1'b0;
      pot_sel    <= 2'd0;
      pot_val    <= 8'h00;
      eep_addr   <= 6'h00;
      eep_wdata  <= 8'h00;
      dump_ch    <= 2'd0;
      gain1      <= 3'd0;
      gain2      <= 3'd0;
      gain3      <= 3'd0;
      trig_lvl   <= 8'h80;
      trig_pos   <= 9'h000;
      decimator  <= 4'h0;
      trig_cfg   <= 6'h00;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      clr_rx_rdy <= accept;
      tx_data    <= tx_nxt;
      trmt       <= trmt_nxt;
      pot_wrt    <= pot_wrt_nxt;
      eep_wrt    <= eep_wrt_nxt;
      eep_rd     <= eep_rd_nxt;
      dump_start <= dump_start_nxt;
      dump_sent  <= dump_sent_nxt;

      if (accept) begin
        case (state)
          BYTE1:   op   <= rx_data;
          BYTE2:   arg2 <= rx_data[5:0];
          default: arg3 <= rx_data;
        endcase
      end

      if (accept || !(state == BYTE2 || state == BYTE3)) tmr <= 20'h0;
      else if (!tmr_hit) tmr <= tmr + 20'd1;

      if (state == DMP_WAIT && dump_vld && !dump_sent) end_pend <= dump_end;

      if (pot_wrt_nxt) begin
        if (op == OP_LVL) begin
          pot_sel  <= 2'd3;
          pot_val  <= arg3;
          trig_lvl <= arg3;
        end else begin
          pot_sel <= arg2[1:0];
          pot_val <= lut_val;
          case (arg2[1:0])
            2'd0:    gain1 <= arg2[4:2];
            2'd1:    gain2 <= arg2[4:2];
            default: gain3 <= arg2[4:2];
          endcase
        end
      end

      if (eep_wrt_nxt || eep_rd_nxt) eep_addr <= arg2;
      if (eep_wrt_nxt) eep_wdata <= arg3;
      if (dump_start_nxt) dump_ch <= arg2[1:0];

      if (state == EXEC && op == OP_POS) trig_pos  <= {arg2[0], arg3};
      if (state == EXEC && op == OP_DEC) decimator <= arg3[3:0];
      // A host write to trig_cfg wins over a coincident capt_done.
      if (state == EXEC && op == OP_CFG) trig_cfg <= arg2;
      else if (capt_done) trig_cfg[5] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Scoreboard bench for cmd_dispatch: stimulus pushes expected port events, a responder
// process models UART/pot/EEPROM timing and checks each DUT pulse against the queues.
module tb_cmd_dispatch;

  localparam int TO = 40;

  logic       clk, rst;
  logic [7:0] rx_data;
  logic       rx_rdy, clr_rx_rdy;
  logic [7:0] tx_data;
  logic       trmt, tx_done;
  logic       pot_wrt;
  logic [1:0] pot_sel;
  logic [7:0] pot_val;
  logic       pot_done;
  logic       eep_wrt, eep_rd;
  logic [5:0] eep_addr;
  logic [7:0] eep_wdata, eep_rdata;
  logic       eep_done;
  logic       dump_start;
  logic [1:0] dump_ch;
  logic [7:0] dump_byte;
  logic       dump_vld, dump_sent, dump_end;
  logic       capt_done;
  logic [2:0] gain1, gain2, gain3;
  logic [7:0] trig_lvl;
  logic [8:0] trig_pos;
  logic [3:0] decimator;
  logic [5:0] trig_cfg;

  cmd_dispatch #(.TIMEOUT(20'(TO))) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .pot_wrt(pot_wrt), .pot_sel(pot_sel), .pot_val(pot_val), .pot_done(pot_done),
    .eep_wrt(eep_wrt), .eep_rd(eep_rd), .eep_addr(eep_addr), .eep_wdata(eep_wdata),
    .eep_rdata(eep_rdata), .eep_done(eep_done),
    .dump_start(dump_start), .dump_ch(dump_ch), .dump_byte(dump_byte),
    .dump_vld(dump_vld), .dump_sent(dump_sent), .dump_end(dump_end),
    .capt_done(capt_done),
    .gain1(gain1), .gain2(gain2), .gain3(gain3),
    .trig_lvl(trig_lvl), .trig_pos(trig_pos), .decimator(decimator), .trig_cfg(trig_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  exp_tx[$];
  logic [9:0]  exp_pot[$];   // {pot_sel, pot_val}
  logic [14:0] exp_eep[$];   // {is_write, addr, wdata (0 for reads)}
  logic [1:0]  exp_dump[$];

  int tx_cnt = 0, pot_cnt = 0, eep_cnt = 0, n_sent = 0;
  logic eep_hold = 1'b0;
  logic [7:0] mem [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event seen or missing contrary to expectation", name);
  endtask

  // Responder: UART tx, pot and EEPROM models plus the scoreboard comparisons.
  initial begin
    tx_done = 1'b0; pot_done = 1'b0; eep_done = 1'b0; eep_rdata = 8'h00;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      tx_done = 1'b0; pot_done = 1'b0; eep_done = 1'b0;
      if (tx_cnt > 0)  begin tx_cnt--;  if (tx_cnt == 0)  tx_done  = 1'b1; end
      if (pot_cnt > 0) begin pot_cnt--; if (pot_cnt == 0) pot_done = 1'b1; end
      if (eep_cnt > 0) begin eep_cnt--; if (eep_cnt == 0) eep_done = 1'b1; end
      if (trmt) begin
        if (exp_tx.size() == 0) fail_event("tx_unexpected");
        else check("tx_byte", tx_data, exp_tx.pop_front());
        tx_cnt = 3;
      end
      if (pot_wrt) begin
        if (exp_pot.size() == 0) fail_event("pot_unexpected");
        else check("pot_sel_val", {pot_sel, pot_val}, exp_pot.pop_front());
        pot_cnt = 2;
      end
      if (eep_wrt || eep_rd) begin
        if (exp_eep.size() == 0) fail_event("eep_unexpected");
        else check("eep_op", {eep_wrt, eep_addr, eep_wrt ? eep_wdata : 8'h00}, exp_eep.pop_front());
        if (eep_wrt) mem[eep_addr] = eep_wdata;
        else eep_rdata = mem[eep_addr];
        eep_cnt = eep_hold ? 12 : 4;
      end
      if (dump_start) begin
        if (exp_dump.size() == 0) fail_event("dump_unexpected");
        else check("dump_ch", dump_ch, exp_dump.pop_front());
      end
      if (dump_sent) n_sent++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    while (!clr_rx_rdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!clr_rx_rdy) fail_event("rx_accept_timeout");
    rx_rdy = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic settle();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_pot.size() != 0 || exp_eep.size() != 0 ||
            exp_dump.size() != 0 || tx_cnt != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_event("settle_timeout");
    repeat (4) @(negedge clk);
  endtask

  task automatic dump_stream(input int nbytes, input logic end_with_last, input logic [7:0] val);
    int n = 0;
    while (!dump_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dump_start) fail_event("dump_start_missing");
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      dump_vld  = 1'b1;
      dump_byte = val;
      dump_end  = end_with_last && (i == nbytes - 1);
      @(negedge clk);
      dump_vld = 1'b0;
      dump_end = 1'b0;
      n = 0;
      while (!dump_sent && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!dump_sent) fail_event("dump_sent_timeout");
    end
    if (!end_with_last) begin
      @(negedge clk);
      dump_end = 1'b1;
      @(negedge clk);
      dump_end = 1'b0;
    end
  endtask

  task automatic expect_cmd_tx(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                               input logic [7:0] resp);
    exp_tx.push_back(resp);
    send_cmd(b1, b2, b3);
    settle();
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0;
    dump_byte = 8'h00; dump_vld = 1'b0; dump_end = 1'b0; capt_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_tx_data", tx_data, 8'h00);
    check("rst_trig_lvl", trig_lvl, 8'h80);
    check("rst_gains", {gain1, gain2, gain3}, 9'h000);
    check("rst_pulses", {clr_rx_rdy, trmt, pot_wrt, eep_wrt, eep_rd, dump_start, dump_sent}, 7'h00);

    // Gain writes: b2 = {g, ch}; ch3 is rejected.
    exp_pot.push_back({2'd2, 8'h57});
    expect_cmd_tx(8'h02, 8'h1E, 8'h00, 8'hA5);
    check("gain3", gain3, 3'd7);
    exp_pot.push_back({2'd1, 8'h09});
    expect_cmd_tx(8'h02, 8'h09, 8'h00, 8'hA5);
    check("gain2", gain2, 3'd2);
    expect_cmd_tx(8'h02, 8'h03, 8'h00, 8'hEE);
    check("gain1_after_nack", gain1, 3'd0);

    // Trigger level with both range edges.
    exp_pot.push_back({2'd3, 8'h2E});
    expect_cmd_tx(8'h03, 8'h00, 8'h2E, 8'hA5);
    exp_pot.push_back({2'd3, 8'hC9});
    expect_cmd_tx(8'h03, 8'h00, 8'hC9, 8'hA5);
    check("trig_lvl_c9", trig_lvl, 8'hC9);
    exp_pot.push_back({2'd3, 8'h80});
    expect_cmd_tx(8'h03, 8'h00, 8'h80, 8'hA5);
    expect_cmd_tx(8'h03, 8'h00, 8'h2D, 8'hEE);
    expect_cmd_tx(8'h03, 8'h00, 8'hCA, 8'hEE);
    check("trig_lvl_kept", trig_lvl, 8'h80);

    // EEPROM write then read back through the model.
    exp_eep.push_back({1'b1, 6'h2A, 8'h99});
    expect_cmd_tx(8'h08, 8'h2A, 8'h99, 8'hA5);
    exp_eep.push_back({1'b0, 6'h2A, 8'h00});
    expect_cmd_tx(8'h09, 8'h2A, 8'h00, 8'h99);

    // Register-only commands.
    expect_cmd_tx(8'h04, 8'h01, 8'h80, 8'hA5);
    check("trig_pos", trig_pos, 9'h180);
    expect_cmd_tx(8'h05, 8'h00, 8'h0F, 8'hA5);
    check("decimator", decimator, 4'hF);
    expect_cmd_tx(8'h06, 8'h3F, 8'h00, 8'hA5);
    expect_cmd_tx(8'h07, 8'h00, 8'h00, 8'h3F);
    expect_cmd_tx(8'h06, 8'h0A, 8'h00, 8'hA5);
    @(negedge clk); capt_done = 1'b1;
    @(negedge clk); capt_done = 1'b0;
    check("trig_cfg_capt", trig_cfg, 6'h2A);
    expect_cmd_tx(8'h07, 8'h00, 8'h00, 8'h2A);

    expect_cmd_tx(8'h0F, 8'h00, 8'h00, 8'hEE);

    // Partial frame abandoned by the inter-byte timeout; 07 then starts a fresh frame.
    send_byte(8'h02);
    send_byte(8'h1C);
    repeat (TO + 4) @(negedge clk);
    expect_cmd_tx(8'h07, 8'h00, 8'h00, 8'h2A);
    check("gain1_after_timeout", gain1, 3'd0);

    // Dump of 20 bytes ended by dump_end, no ACK afterwards.
    exp_dump.push_back(2'd1);
    for (int i = 0; i < 20; i++) exp_tx.push_back(8'hAA);
    send_cmd(8'h01, 8'h01, 8'h00);
    dump_stream(20, 1'b0, 8'hAA);
    settle();
    check("dump_sent_count", n_sent, 20);
    expect_cmd_tx(8'h07, 8'h00, 8'h00, 8'h2A);
    expect_cmd_tx(8'h01, 8'h03, 8'h00, 8'hEE);

    // dump_end coincident with the last dump_vld: byte still goes out.
    exp_dump.push_back(2'd0);
    exp_tx.push_back(8'h55);
    exp_tx.push_back(8'h55);
    send_cmd(8'h01, 8'h00, 8'h00);
    dump_stream(2, 1'b1, 8'h55);
    settle();
    check("dump_sent_count2", n_sent, 22);
    expect_cmd_tx(8'h07, 8'h00, 8'h00, 8'h2A);

    // Reset while waiting on the EEPROM; its late eep_done must be ignored.
    eep_hold = 1'b1;
    exp_eep.push_back({1'b1, 6'h05, 8'h11});
    send_cmd(8'h08, 8'h05, 8'h11);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_regs", {trig_lvl, trig_pos, decimator, trig_cfg}, {8'h80, 9'h000, 4'h0, 6'h00});
    check("rst2_gains", {gain1, gain2, gain3}, 9'h000);
    check("rst2_ports", {tx_data, pot_sel, pot_val, eep_addr, dump_ch}, {8'h00, 2'd0, 8'h00, 6'h00, 2'd0});
    check("rst2_pulses", {trmt, eep_wrt, eep_rd, pot_wrt, dump_start}, 5'h00);
    repeat (15) @(negedge clk);
    eep_hold = 1'b0;
    expect_cmd_tx(8'h07, 8'h00, 8'h00, 8'h00);

    check("tx_queue_drained", exp_tx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
